// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and width helpers for the synchronous FIFO.
//   clog2()  : ceiling log2 usable in parameter and port-width expressions
//   ptr_w()  : pointer / occupancy width for a given depth (one extra wrap bit)
//   DEF_DATA_W, DEF_DEPTH : default word width and entry count
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // The extra MSB lets equal-index pointers distinguish full from empty.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W storage array for param_sync_fifo: synchronous write,
// asynchronous (combinational) read.
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write strobe (already qualified by the FIFO control)
//   i_wr_addr  write index
//   i_wr_data  write data
//   i_rd_addr  read index
//   o_rd_data  word at i_rd_addr, combinational
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset -- its contents are only ever read behind the
  // pointers, so clearing it would just cost a reset fan-out into every bit and
  // prevent mapping onto RAM primitives.
  // NOTE: state is always updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with registered occupancy/status flags, selectable
// standard or first-word-fall-through read, and optional sticky error flags.
// Optional feature macro: FIFO_ERR_FLAGS_EN (compiles in overflow/underflow).
// Parameters: DATA_W, DEPTH (power of two, >= 4), AF_THRESH, AE_THRESH, FWFT.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr_en, din          push request and data
//   rd_en, dout         pop request and read data
//   full, empty         occupancy == DEPTH / == 0
//   almost_full         count >= AF_THRESH
//   almost_empty        count <= AE_THRESH
//   count               occupancy 0..DEPTH
//   err_clr             clears the sticky error flags
//   overflow, underflow sticky: write dropped while full / read dropped while empty
// -----------------------------------------------------------------------------
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  input  logic                      err_clr,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_count;
  logic              r_full, r_empty, r_almost_full, r_almost_empty;
  logic              w_wr_acc, w_rd_acc;
  logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic [DATA_W-1:0] w_mem_rd;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // when the read is accepted alongside it.
  always_comb begin
    w_rd_acc     = rd_en & ~r_empty;
    w_wr_acc     = wr_en & (~r_full | w_rd_acc);
    w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    w_count_nxt  = r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
  end

  // Flags are computed from next-state values and registered, so they are
  // glitch-free and valid the cycle after the operation that changed them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_full         <= (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      r_empty        <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_almost_full  <= (w_count_nxt >= AF_LVL);
      r_almost_empty <= (w_count_nxt <= AE_LVL);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc & ~rst),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (din),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_mem_rd)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible directly; forced to zero while empty so the
      // output is defined out of reset even though the array is not.
      assign dout = r_empty ? '0 : w_mem_rd;
    end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= w_mem_rd;
        end
      end
      assign dout = r_dout;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  // A new error in the same cycle as err_clr wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~err_clr) | (wr_en & ~w_wr_acc);
      r_underflow <= (r_underflow & ~err_clr) | (rd_en & ~w_rd_acc);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;

endmodule
